// File: rtl/hwpe_stream_sink_writer_pkg.sv
// Shared types for the HWPE stream sink writer: control/flag structs and FSM states.
package hwpe_stream_package;

  typedef enum logic {
    SINK_IDLE    = 1'b0,
    SINK_WORKING = 1'b1
  } sink_state_e;

  typedef struct packed {
    logic [31:0] base_addr;
    logic [15:0] trans_size;
    logic [15:0] line_length;
    logic [15:0] line_stride;
    logic        req_start;
  } ctrl_sink_writer_t;

  typedef struct packed {
    logic ready_start;
    logic done;
    logic in_progress;
  } flags_sink_writer_t;

  // A line length of zero behaves as a single-beat line.
  function automatic logic [15:0] eff_line_len(input logic [15:0] len);
    return (len == 16'd0) ? 16'd1 : len;
  endfunction

endpackage

// File: rtl/hwpe_stream_sink_addrgen.sv
// 2-D address generator for the sink writer: word/line/beat counters and beat address.
module hwpe_stream_sink_addrgen
  import hwpe_stream_package::*;
#(
  parameter int unsigned NB_TCDM_PORTS = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic        enable_i,
  input  logic [31:0] base_addr_i,
  input  logic [15:0] trans_size_i,
  input  logic [15:0] line_length_i,
  input  logic [15:0] line_stride_i,
  output logic [31:0] addr_o,
  output logic        last_o
);

  localparam logic [31:0] WORD_STEP = 32'(NB_TCDM_PORTS * 4);

  logic [15:0] word_q, word_d;
  logic [15:0] line_q, line_d;
  logic [15:0] beat_q, beat_d;
  logic [15:0] len_eff;

  assign len_eff = eff_line_len(line_length_i);

  always_comb begin
    word_d = word_q;
    line_d = line_q;
    beat_d = beat_q;
    if (clear_i) begin
      word_d = '0;
      line_d = '0;
      beat_d = '0;
    end else if (enable_i) begin
      beat_d = beat_q + 16'd1;
      if (word_q == len_eff - 16'd1) begin
        word_d = '0;
        line_d = line_q + 16'd1;
      end else begin
        word_d = word_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      word_q <= '0;
      line_q <= '0;
      beat_q <= '0;
    end else begin
      word_q <= word_d;
      line_q <= line_d;
      beat_q <= beat_d;
    end
  end

  // All terms wrap modulo 2^32.
  assign addr_o = base_addr_i
                + ({16'd0, line_q} * {16'd0, line_stride_i})
                + ({16'd0, word_q} * WORD_STEP);
  assign last_o = (beat_q == trans_size_i - 16'd1);

endmodule

// File: rtl/hwpe_stream_sink_writer.sv
// Stream-to-TCDM sink writer with per-port partial grant tracking.
// Optional: HWPE_STREAM_SINK_SKIP_EMPTY_EN suppresses requests on all-zero-strobe ports.
module hwpe_stream_sink_writer
  import hwpe_stream_package::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned NB_TCDM_PORTS = DATA_WIDTH / 32
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         clear_i,
  input  logic                         stream_valid_i,
  output logic                         stream_ready_o,
  input  logic [DATA_WIDTH-1:0]        stream_data_i,
  input  logic [DATA_WIDTH/8-1:0]      stream_strb_i,
  output logic [NB_TCDM_PORTS-1:0]     tcdm_req_o,
  input  logic [NB_TCDM_PORTS-1:0]     tcdm_gnt_i,
  output logic [32*NB_TCDM_PORTS-1:0]  tcdm_add_o,
  output logic [NB_TCDM_PORTS-1:0]     tcdm_wen_o,
  output logic [4*NB_TCDM_PORTS-1:0]   tcdm_be_o,
  output logic [32*NB_TCDM_PORTS-1:0]  tcdm_data_o,
  input  logic                         ctrl_req_start_i,
  input  logic [31:0]                  ctrl_base_addr_i,
  input  logic [15:0]                  ctrl_trans_size_i,
  input  logic [15:0]                  ctrl_line_length_i,
  input  logic [15:0]                  ctrl_line_stride_i,
  output logic                         ready_start_o,
  output logic                         done_o,
  output logic                         in_progress_o
);

  ctrl_sink_writer_t  ctrl_in;
  flags_sink_writer_t flags;
  sink_state_e        state_q, state_d;

  logic [31:0] base_q, base_d;
  logic [15:0] size_q, size_d, len_q, len_d, stride_q, stride_d;
  logic [NB_TCDM_PORTS-1:0] gmask_q, gmask_d, active;
  logic done_q, done_d;
  logic start, xfer_en, all_cov, beat_done, last;
  logic [31:0] addr;

  assign ctrl_in = '{base_addr:   ctrl_base_addr_i,
                     trans_size:  ctrl_trans_size_i,
                     line_length: ctrl_line_length_i,
                     line_stride: ctrl_line_stride_i,
                     req_start:   ctrl_req_start_i};

  assign xfer_en = (state_q == SINK_WORKING) && stream_valid_i && (size_q != 16'd0);

  for (genvar k = 0; k < NB_TCDM_PORTS; k++) begin : g_port
`ifdef HWPE_STREAM_SINK_SKIP_EMPTY_EN
    assign active[k] = |stream_strb_i[4*k +: 4];
`else
    assign active[k] = 1'b1;
`endif
    assign tcdm_req_o[k]           = xfer_en & active[k] & ~gmask_q[k];
    assign tcdm_add_o[32*k +: 32]  = addr + 32'(4 * k);
    assign tcdm_be_o[4*k +: 4]     = stream_strb_i[4*k +: 4];
    assign tcdm_data_o[32*k +: 32] = stream_data_i[32*k +: 32];
  end

  assign tcdm_wen_o = '0;

  // Inactive ports count as already granted; clear abandons the beat unacknowledged.
  assign all_cov        = &(gmask_q | (tcdm_gnt_i & tcdm_req_o) | ~active);
  assign beat_done      = xfer_en & all_cov & ~clear_i;
  assign stream_ready_o = beat_done;

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    size_d   = size_q;
    len_d    = len_q;
    stride_d = stride_q;
    gmask_d  = gmask_q;
    done_d   = 1'b0;
    start    = 1'b0;
    case (state_q)
      SINK_IDLE: begin
        if (ctrl_in.req_start) begin
          start    = 1'b1;
          state_d  = SINK_WORKING;
          base_d   = ctrl_in.base_addr;
          size_d   = ctrl_in.trans_size;
          len_d    = ctrl_in.line_length;
          stride_d = ctrl_in.line_stride;
        end
      end
      SINK_WORKING: begin
        if (size_q == 16'd0) begin
          state_d = SINK_IDLE;
          done_d  = 1'b1;
        end else if (beat_done) begin
          gmask_d = '0;
          if (last) begin
            state_d = SINK_IDLE;
            done_d  = 1'b1;
          end
        end else if (stream_valid_i) begin
          gmask_d = gmask_q | (tcdm_gnt_i & tcdm_req_o);
        end
      end
      default: state_d = SINK_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= SINK_IDLE;
      base_q   <= '0;
      size_q   <= '0;
      len_q    <= '0;
      stride_q <= '0;
      gmask_q  <= '0;
      done_q   <= 1'b0;
    end else if (clear_i) begin
      state_q  <= SINK_IDLE;
      base_q   <= '0;
      size_q   <= '0;
      len_q    <= '0;
      stride_q <= '0;
      gmask_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      size_q   <= size_d;
      len_q    <= len_d;
      stride_q <= stride_d;
      gmask_q  <= gmask_d;
      done_q   <= done_d;
    end
  end

  hwpe_stream_sink_addrgen #(
    .NB_TCDM_PORTS (NB_TCDM_PORTS)
  ) i_addrgen (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .clear_i       (clear_i | start),
    .enable_i      (beat_done),
    .base_addr_i   (base_q),
    .trans_size_i  (size_q),
    .line_length_i (len_q),
    .line_stride_i (stride_q),
    .addr_o        (addr),
    .last_o        (last)
  );

  assign flags.ready_start = (state_q == SINK_IDLE);
  assign flags.in_progress = (state_q == SINK_WORKING);
  assign flags.done        = done_q;

  assign ready_start_o = flags.ready_start;
  assign in_progress_o = flags.in_progress;
  assign done_o        = flags.done;

endmodule

// File: tb/tb_hwpe_stream_sink_writer.sv
// Scoreboard bench for hwpe_stream_sink_writer with two TCDM ports (DATA_WIDTH=64).
module tb_hwpe_stream_sink_writer;

  typedef struct {
    logic [31:0] addr;
    logic [63:0] data;
    logic [7:0]  strb;
  } beat_t;

  logic        clk, rst, clear, valid, sready;
  logic [63:0] data, add, tdata;
  logic [7:0]  strb, be;
  logic [1:0]  req, gnt, wen;
  logic        req_start, ready_start, done, in_prog;
  logic [31:0] base;
  logic [15:0] size, llen, stride;

  beat_t sb[$];
  int checks = 0;
  int passes = 0;

  hwpe_stream_sink_writer #(.DATA_WIDTH(64)) dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clear),
    .stream_valid_i(valid), .stream_ready_o(sready),
    .stream_data_i(data), .stream_strb_i(strb),
    .tcdm_req_o(req), .tcdm_gnt_i(gnt), .tcdm_add_o(add), .tcdm_wen_o(wen),
    .tcdm_be_o(be), .tcdm_data_o(tdata),
    .ctrl_req_start_i(req_start), .ctrl_base_addr_i(base),
    .ctrl_trans_size_i(size), .ctrl_line_length_i(llen), .ctrl_line_stride_i(stride),
    .ready_start_o(ready_start), .done_o(done), .in_progress_o(in_prog)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control inputs are scrambled after the start cycle to show they were latched.
  task automatic start_xfer(input logic [31:0] b, input logic [15:0] s,
                            input logic [15:0] l, input logic [15:0] st);
    @(posedge clk); #1;
    req_start = 1'b1; base = b; size = s; llen = l; stride = st;
    @(posedge clk); #1;
    req_start = 1'b0; base = 32'hDEAD_0000; size = 16'd99; llen = 16'd7; stride = 16'h0040;
  endtask

  task automatic test_reset();
    valid = 1'b1; data = 64'h1; strb = 8'hFF; gnt = 2'b11;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (req !== 2'b00) $display("FAIL reset_req: got %b want 00", req); else passes++;
    checks++; if (sready !== 1'b0) $display("FAIL reset_ready: got %b want 0", sready); else passes++;
    checks++; if ({ready_start, done, in_prog} !== 3'b100)
      $display("FAIL reset_flags: got %b want 100", {ready_start, done, in_prog}); else passes++;
    checks++; if (wen !== 2'b00) $display("FAIL reset_wen: got %b want 00", wen); else passes++;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (sready !== 1'b0) $display("FAIL idle_ready: got %b want 0", sready); else passes++;
    valid = 1'b0; gnt = 2'b00;
  endtask

  task automatic test_stream(input string nm, input logic [31:0] b, input int n,
                             input int l, input logic [15:0] st);
    int    le;
    beat_t e, x;
    le = (l == 0) ? 1 : l;
    start_xfer(b, 16'(n), 16'(l), st);
    gnt = 2'b11;
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      x.data = {$urandom, $urandom};
      x.strb = 8'hFF;
      x.addr = b + 32'((i / le) * int'(st)) + 32'((i % le) * 8);
      data = x.data; strb = x.strb; valid = 1'b1;
      sb.push_back(x);
      @(negedge clk);
      checks++; if (sready !== 1'b1) $display("FAIL %s_ready beat %0d: got %b want 1", nm, i, sready); else passes++;
      checks++; if (req !== 2'b11) $display("FAIL %s_req beat %0d: got %b want 11", nm, i, req); else passes++;
      if (sready === 1'b1 && sb.size() > 0) begin
        e = sb.pop_front();
        checks++; if (add !== {e.addr + 32'd4, e.addr})
          $display("FAIL %s_addr beat %0d: got %h want %h", nm, i, add, {e.addr + 32'd4, e.addr}); else passes++;
        checks++; if (tdata !== e.data || be !== e.strb)
          $display("FAIL %s_data beat %0d: got %h/%h want %h/%h", nm, i, tdata, be, e.data, e.strb); else passes++;
      end
    end
    @(posedge clk); #1;
    valid = 1'b0; gnt = 2'b00;
    @(negedge clk);
    checks++; if ({ready_start, done, in_prog} !== 3'b110)
      $display("FAIL %s_done: got %b want 110", nm, {ready_start, done, in_prog}); else passes++;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (done !== 1'b0) $display("FAIL %s_done_pulse: got %b want 0", nm, done); else passes++;
  endtask

  task automatic test_partial();
    beat_t e, x;
    start_xfer(32'h2000, 16'd1, 16'd1, 16'd0);
    x.addr = 32'h2000; x.data = 64'hCAFE_0001_BEEF_0002; x.strb = 8'hFF;
    data = x.data; strb = x.strb; valid = 1'b1; gnt = 2'b01;
    sb.push_back(x);
    @(negedge clk);
    checks++; if (req !== 2'b11 || sready !== 1'b0)
      $display("FAIL partial_c1: got req %b rdy %b want 11/0", req, sready); else passes++;
    @(posedge clk); #1; gnt = 2'b00;
    @(negedge clk);
    checks++; if (req !== 2'b10 || sready !== 1'b0)
      $display("FAIL partial_c2: got req %b rdy %b want 10/0", req, sready); else passes++;
    @(posedge clk); #1; gnt = 2'b10;
    @(negedge clk);
    checks++; if (req !== 2'b10 || sready !== 1'b1)
      $display("FAIL partial_c3: got req %b rdy %b want 10/1", req, sready); else passes++;
    if (sready === 1'b1 && sb.size() > 0) begin
      e = sb.pop_front();
      checks++; if (add[31:0] !== e.addr || tdata !== e.data)
        $display("FAIL partial_beat: got %h/%h want %h/%h", add[31:0], tdata, e.addr, e.data); else passes++;
    end
    @(posedge clk); #1; valid = 1'b0; gnt = 2'b00;
    @(negedge clk);
    checks++; if (done !== 1'b1) $display("FAIL partial_done: got %b want 1", done); else passes++;
  endtask

  task automatic test_zero();
    start_xfer(32'h0, 16'd0, 16'd1, 16'd0);
    valid = 1'b1; strb = 8'hFF; gnt = 2'b11;
    @(negedge clk);
    checks++; if (req !== 2'b00 || sready !== 1'b0 || done !== 1'b0)
      $display("FAIL zero_c1: got req %b rdy %b done %b want 00/0/0", req, sready, done); else passes++;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (done !== 1'b1 || ready_start !== 1'b1)
      $display("FAIL zero_done: got done %b rs %b want 1/1", done, ready_start); else passes++;
    @(posedge clk); #1; valid = 1'b0; gnt = 2'b00;
    @(negedge clk);
    checks++; if (done !== 1'b0) $display("FAIL zero_pulse: got %b want 0", done); else passes++;
  endtask

  task automatic test_strobe();
    beat_t e, x;
    start_xfer(32'h4000, 16'd1, 16'd1, 16'd0);
    x.addr = 32'h4000; x.data = 64'h0000_0000_1234_5678; x.strb = 8'h0F;
    data = x.data; strb = x.strb; valid = 1'b1; gnt = 2'b01;
    sb.push_back(x);
    @(negedge clk);
`ifdef HWPE_STREAM_SINK_SKIP_EMPTY_EN
    checks++; if (req !== 2'b01 || sready !== 1'b1)
      $display("FAIL strobe_skip: got req %b rdy %b want 01/1", req, sready); else passes++;
`else
    checks++; if (req !== 2'b11 || sready !== 1'b0)
      $display("FAIL strobe_all: got req %b rdy %b want 11/0", req, sready); else passes++;
    @(posedge clk); #1; gnt = 2'b10;
    @(negedge clk);
    checks++; if (req !== 2'b10 || sready !== 1'b1)
      $display("FAIL strobe_c2: got req %b rdy %b want 10/1", req, sready); else passes++;
`endif
    if (sready === 1'b1 && sb.size() > 0) begin
      e = sb.pop_front();
      checks++; if (be !== e.strb || add[31:0] !== e.addr)
        $display("FAIL strobe_be: got %h/%h want %h/%h", be, add[31:0], e.strb, e.addr); else passes++;
    end
    @(posedge clk); #1; valid = 1'b0; gnt = 2'b00; strb = 8'hFF;
    @(negedge clk);
    checks++; if (done !== 1'b1) $display("FAIL strobe_done: got %b want 1", done); else passes++;
  endtask

  task automatic test_clear();
    start_xfer(32'h5000, 16'd2, 16'd2, 16'd0);
    valid = 1'b1; strb = 8'hFF; gnt = 2'b11; clear = 1'b1;
    @(negedge clk);
    checks++; if (sready !== 1'b0) $display("FAIL clear_ready: got %b want 0", sready); else passes++;
    @(posedge clk); #1; clear = 1'b0; valid = 1'b0; gnt = 2'b00;
    @(negedge clk);
    checks++; if ({ready_start, done, in_prog} !== 3'b100 || req !== 2'b00)
      $display("FAIL clear_state: got %b req %b want 100/00", {ready_start, done, in_prog}, req); else passes++;
  endtask

  task automatic test_reset_mid();
    start_xfer(32'h3000, 16'd4, 16'd4, 16'd0);
    valid = 1'b1; strb = 8'hFF; data = 64'h55; gnt = 2'b01;
    @(negedge clk);
    checks++; if (sready !== 1'b0) $display("FAIL rmid_ready: got %b want 0", sready); else passes++;
    @(posedge clk); #1; gnt = 2'b00;
    @(negedge clk);
    checks++; if (req !== 2'b10) $display("FAIL rmid_pending: got %b want 10", req); else passes++;
    #1 rst = 1'b1;
    #1;
    checks++; if (req !== 2'b00 || sready !== 1'b0 || {ready_start, done, in_prog} !== 3'b100)
      $display("FAIL rmid_async: got req %b rdy %b flags %b want 00/0/100",
               req, sready, {ready_start, done, in_prog}); else passes++;
    sb.delete();
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    checks++; if (sready !== 1'b0) $display("FAIL rmid_idle_ready: got %b want 0", sready); else passes++;
    valid = 1'b0;
    test_stream("restart", 32'h3000, 2, 2, 16'd0);
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; valid = 1'b0; data = '0; strb = '0; gnt = '0;
    req_start = 1'b0; base = '0; size = '0; llen = '0; stride = '0;
    test_reset();
    test_stream("linear", 32'h1000, 4, 4, 16'd0);
    test_stream("stride", 32'h0, 6, 2, 16'h0100);
    test_partial();
    test_zero();
    test_strobe();
    test_clear();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/hwpe_stream_sink_writer.md
Name: hwpe_stream_sink_writer

Overview:
- Write-side counterpart of the TCDM read source: consumes one HWPE stream and writes it beat by beat to memory through NB_TCDM_PORTS 32-bit TCDM master ports.
- Carries its own 2-D address generator (linear word step within a line, programmable stride between lines).
- Handles per-port partial grants; sits at the output end of an HWPE datapath, driven by the engine controller through a start/done handshake.

Parameters:
- DATA_WIDTH, 32, stream data width in bits; multiple of 32.
- NB_TCDM_PORTS, DATA_WIDTH/32, number of TCDM ports; port k carries bits [32k+31:32k].

Ports:
- clk_i  in  1  clock; all state on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- clear_i  in  1  synchronous clear; same effect as reset.
- stream_valid_i  in  1  input beat valid.
- stream_ready_o  out  1  input beat accepted.
- stream_data_i  in  DATA_WIDTH  beat data.
- stream_strb_i  in  DATA_WIDTH/8  byte strobes.
- tcdm_req_o  out  NB_TCDM_PORTS  per-port request.
- tcdm_gnt_i  in  NB_TCDM_PORTS  per-port grant.
- tcdm_add_o  out  32*NB_TCDM_PORTS  byte address per port.
- tcdm_wen_o  out  NB_TCDM_PORTS  write enable, active-low; constant 0.
- tcdm_be_o  out  4*NB_TCDM_PORTS  byte enables.
- tcdm_data_o  out  32*NB_TCDM_PORTS  write data.
- ctrl_req_start_i  in  1  start request, sampled in IDLE.
- ctrl_base_addr_i  in  32  first byte address; word-aligned.
- ctrl_trans_size_i  in  16  total beats.
- ctrl_line_length_i  in  16  beats per line; 0 is treated as 1.
- ctrl_line_stride_i  in  16  byte stride between line starts.
- ready_start_o  out  1  high in IDLE.
- done_o  out  1  one-cycle pulse at transfer end.
- in_progress_o  out  1  high in WORKING.

Behaviour:
- Reset/clear values: state IDLE; all counters 0; granted mask 0; done_o 0; tcdm_req_o 0; stream_ready_o 0.
- FSM states: IDLE, WORKING.
- IDLE -> WORKING on ctrl_req_start_i. Control inputs are latched that cycle; later changes are ignored until the next start.
- If the latched trans_size is 0, go straight back to IDLE and pulse done_o one cycle later.
- Beat address: addr = base + line_idx*line_stride + word_idx*NB_TCDM_PORTS*4, in 32-bit modulo arithmetic. Port k address = addr + 4k.
- word_idx increments per completed beat. On reaching line_length-1 it wraps to 0 and line_idx increments.
- In WORKING with stream_valid_i=1:
  - tcdm_req_o[k] = ~granted_mask[k].
  - tcdm_be_o[k] = strb slice k; tcdm_data_o = data.
- Beat completes in the cycle where (granted_mask | tcdm_gnt_i) covers all requesting ports.
  - That cycle: stream_ready_o=1, granted_mask cleared, beat counter increments.
  - Otherwise granted_mask |= tcdm_gnt_i & tcdm_req_o, and stream_ready_o=0.
- Zero added latency: a beat whose ports are all granted in the first cycle is accepted in that same cycle.
- A granted port never re-issues its request for the same beat. Req is held until gnt (standard TCDM).
- stream_valid_i=0 in WORKING: no requests; granted_mask holds. A source never drops valid mid-beat.
- The last beat (count == trans_size-1) completing: -> IDLE; done_o registered high the following cycle for exactly one cycle.
- stream_ready_o is 0 in IDLE; beats presented in IDLE are not consumed.
- Simultaneous clear_i and grant: clear wins; the in-flight partial beat is abandoned and the stream beat is not acknowledged.
- Reset mid-operation: immediate return to IDLE with all outputs at reset values.

Optional Feature:
- Macro: HWPE_STREAM_SINK_SKIP_EMPTY_EN.
- Defined:
  - A port whose 4 strobe bits are all 0 issues no request and counts as granted.
  - A beat with all strobes 0 completes in the cycle it is valid.
- Undefined: every port requests every beat regardless of strobes; be still follows strb.

Decomposition:
- Shared package (hwpe_stream_package): ctrl_sink_writer_t (base, trans_size, line_length, line_stride, req_start), flags_sink_writer_t (ready_start, done, in_progress), state enum {SINK_IDLE, SINK_WORKING}.
- One natural sub-module: hwpe_stream_sink_addrgen. It holds word/line/beat counters and the address computation, with enable/clear inputs and a last-beat flag.

Test Plan:
- Base 0x1000, size 4, line_len 4, NB=2, all gnt=1 -> writes at 0x1000/4, 0x1008/C, 0x1010/14, 0x1018/1C; ready every cycle; done_o one cycle after 4th beat.
- Size 6, line_len 2, stride 0x100, NB=1 -> addresses 0x0, 0x4, 0x100, 0x104, 0x200, 0x204.
- NB=2: port0 gnt in cycle 1, port1 gnt in cycle 3 -> port0 req drops after cycle 1; ready only in cycle 3; one beat counted.
- trans_size 0 start -> no req; done_o pulses 2 cycles after start; back to IDLE.
- rst_i asserted mid-transfer with a pending partial grant -> outputs zero immediately; a new start restarts at base.
- With SKIP_EMPTY_EN, NB=2, strb=0x0F -> only port0 requests; beat completes on port0 gnt alone.
